// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the control decoder:
// opcode encodings, default widths and the opcode field position.
package instr_fetch_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int INSTR_W_DEF = 8;
  localparam int OPC_MSB     = 7;
  localparam int OPC_LSB     = 6;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_RSV  = 2'b10,
    OP_JMP  = 2'b11
  } opcode_e;

  function automatic logic is_jump(input logic [1:0] opc);
    return (opc == OP_JMP);
  endfunction

endpackage

// File: rtl/instr_fetch_mem.sv
// Loadable instruction store: synchronous write, asynchronous read.
// A read of the address being written this cycle returns the old word.
module instr_mem
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [2**ADDR_W];

  // Program-load write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage with PC, IF/ID register and one-bubble jump redirect.
// Priority: reset > load_en > stall > jump > sequential.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [INSTR_W-1:0] instr,
  output logic [1:0]         opcode,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  output logic               illegal
);

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic               r_valid;
  logic [INSTR_W-1:0] w_rdata;
  logic [1:0]         w_opcode;
  logic               w_redirect;

  // Memory write happens even when reset is asserted in the same cycle.
  instr_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (load_en),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign w_opcode   = r_instr[OPC_MSB:OPC_LSB];
  assign w_redirect = r_valid && is_jump(w_opcode);

  // PC and IF/ID register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (load_en) begin
      r_valid  <= 1'b0;
    end else if (stall) begin
      r_pc     <= r_pc;
      r_instr  <= r_instr;
      r_pc_out <= r_pc_out;
      r_valid  <= r_valid;
    end else if (w_redirect) begin
      // Sequential word is still captured but squashed as a bubble.
      r_pc     <= r_instr[ADDR_W-1:0];
      r_instr  <= w_rdata;
      r_pc_out <= r_pc;
      r_valid  <= 1'b0;
    end else begin
      r_pc     <= r_pc + ADDR_W'(1);
      r_instr  <= w_rdata;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
    end
  end

  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign opcode      = w_opcode;
  assign illegal     = r_valid && (w_opcode == OP_RSV);

endmodule
